clk_div_monitor: RTL



---
 rtl/clk_div_monitor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: watches a divided clock from inside the fast clock domain.
// The divided clock is synchronised, turned into single-cycle rise/fall
// enables, and its period and high time are measured in fast-clock cycles.
// A small state machine decides when the measured ratio is stable enough to
// call the divider locked, and remembers any loss of lock in a sticky flag.
//
// Handshake: there is no valid/ready flow control here. meas_valid is a
// one-cycle strobe, qualifying period on the cycle it is high. rise_pulse and
// fall_pulse are one-cycle strobes that consumers may use as clock enables.
// Nothing in this block waits for an acknowledge.
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_DIV  = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             err_clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_sticky
);

    // Lock counter only needs to count up to LOCK_CNT.
    localparam int LC_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_CNT);

    // Tolerance window for a good period, clamped at zero on the low side.
    localparam logic [31:0] GOOD_LO = (EXP_DIV > TOL) ? 32'(EXP_DIV - TOL) : 32'd0;
    localparam logic [31:0] GOOD_HI = 32'(EXP_DIV + TOL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_MEAS  = 2'd2
    } state_t;

    // Synchroniser and edge history.
    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fall;

    // Measurement state.
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] cyc_d;
    logic [CNT_W-1:0] meas_val;
    logic             cyc_sat;
    logic [31:0]      meas_ext;
    logic             good;

    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_time_d;
    logic             meas_valid_d;
    logic [LC_W-1:0]  lock_cnt;
    logic [LC_W-1:0]  lock_cnt_d;
    logic [LC_W-1:0]  lock_cnt_inc;
    logic             locked_d;
    logic             set_err;
    logic             err_sticky_d;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Edge enables are registered so they align with period/meas_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise;
            fall_pulse <= fall;
        end
    end

    // Measured distance is the count plus the edge cycle itself, saturating.
    assign cyc_sat  = (cyc == CNT_MAX);
    assign meas_val = cyc_sat ? CNT_MAX : (cyc + 1'b1);
    assign meas_ext = 32'(meas_val);
    assign good     = (meas_ext >= GOOD_LO) && (meas_ext <= GOOD_HI);

    assign lock_cnt_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : (lock_cnt + 1'b1);

    // Next-state, measurement capture, lock evaluation and timeout handling.
    always_comb begin
        state_d      = state_q;
        cyc_d        = rise ? '0 : (cyc_sat ? cyc : (cyc + 1'b1));
        period_d     = period;
        high_time_d  = high_time;
        meas_valid_d = 1'b0;
        lock_cnt_d   = lock_cnt;
        locked_d     = locked;
        set_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first rise only arms; a lone fall is ignored.
                if (rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED, ST_MEAS: begin
                if (rise) begin
                    // A rise that lands on the saturated count is still a
                    // measurement; it will simply be judged a bad period.
                    state_d      = ST_MEAS;
                    period_d     = meas_val;
                    meas_valid_d = 1'b1;
                    if (good) begin
                        lock_cnt_d = lock_cnt_inc;
                        if (lock_cnt_inc == LOCK_MAX) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        set_err    = locked;
                    end
                end else if (cyc_sat) begin
                    // Divider stuck: drop back and wait to re-arm.
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                    set_err    = locked;
                end else if (fall) begin
                    high_time_d = meas_val;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a simultaneous clear.
        err_sticky_d = set_err | (err_sticky & ~err_clr);
    end

    // State and measurement registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cyc        <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc        <= cyc_d;
            period     <= period_d;
            high_time  <= high_time_d;
            meas_valid <= meas_valid_d;
            lock_cnt   <= lock_cnt_d;
            locked     <= locked_d;
            err_sticky <= err_sticky_d;
        end
    end

endmodule
